// File: rtl/gray_pkg.sv
// Shared definitions for the sequential Gray-to-binary decoder.
// Holds the FSM state encoding and the default data width.
package gray_pkg;

  localparam int GRAY_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gray_step_check.sv
// Combinational step checker: o_err=1 unless the two words differ in exactly one bit.
// No latency, no flow control; a single-bit difference is a one-hot XOR.
module gray_step_check
  import gray_pkg::*;
#(
  parameter int W = GRAY_W_DEFAULT
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_err
);

  logic [W-1:0] w_diff;
  logic         w_nonzero;
  logic         w_pow2;

  assign w_diff    = i_a ^ i_b;
  assign w_nonzero = (w_diff != '0);
  // Clearing the lowest set bit leaves zero only for a one-hot value.
  assign w_pow2    = ((w_diff & (w_diff - W'(1))) == '0);
  assign o_err     = ~(w_nonzero & w_pow2);

endmodule

// File: rtl/gray2bin_seq.sv
// Bit-serial Gray-to-binary decoder: accept in IDLE, W decode cycles MSB first, hold in DONE.
// Result visible W edges after the accept edge; held until OUT_READY, one word per W+2 cycles.
module gray2bin_seq
  import gray_pkg::*;
#(
  parameter int W = GRAY_W_DEFAULT
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [W-1:0] GRAY,
  input  logic         IN_VALID,
  output logic         IN_READY,
  output logic [W-1:0] BIN,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic         STEP_ERR
);

  localparam int IW = $clog2(W);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_gray;
  logic [W-1:0]   r_bin;
  logic [W-1:0]   r_prev_gray;
  logic [IW-1:0]  r_idx;
  logic           r_prev_vld;
  logic           r_step_err;

  logic           w_accept;
  logic           w_in_ready;
  logic           w_out_valid;
  logic           w_step_err;
  logic           w_dec_bit;

  gray_step_check #(
    .W(W)
  ) u_step_check (
    .i_a  (GRAY),
    .i_b  (r_prev_gray),
    .o_err(w_step_err)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (IN_VALID) w_state_nxt = CONV;
      end
      CONV: begin
        if (r_idx == '0) w_state_nxt = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (OUT_READY) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept = (r_state == IDLE) & IN_VALID;

  // The MSB copies straight through; every lower bit folds in the bit decoded above it.
  always_comb begin
    w_dec_bit = r_gray[r_idx];
    if (r_idx != IW'(W - 1)) w_dec_bit = r_bin[r_idx + IW'(1)] ^ r_gray[r_idx];
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_gray      <= '0;
      r_bin       <= '0;
      r_prev_gray <= '0;
      r_idx       <= IW'(W - 1);
      r_prev_vld  <= 1'b0;
      r_step_err  <= 1'b0;
    end else if (w_accept) begin
      r_gray      <= GRAY;
      r_bin       <= '0;
      r_idx       <= IW'(W - 1);
      // First word after reset has no predecessor to compare against.
      r_step_err  <= r_prev_vld & w_step_err;
      r_prev_gray <= GRAY;
      r_prev_vld  <= 1'b1;
    end else if (r_state == CONV) begin
      r_bin[r_idx] <= w_dec_bit;
      if (r_idx != '0) r_idx <= r_idx - IW'(1);
    end
  end

  assign IN_READY  = w_in_ready;
  assign OUT_VALID = w_out_valid;
  assign BIN       = r_bin;
  assign STEP_ERR  = r_step_err;

endmodule

// File: tb/tb_gray2bin_seq.sv
// Bench for gray2bin_seq at W=4, randomized words checked against an arithmetic reference.
module tb_gray2bin_seq;

  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic [W-1:0] GRAY = '0;
  logic         IN_VALID = 1'b0;
  logic         OUT_READY = 1'b0;
  logic         IN_READY;
  logic [W-1:0] BIN;
  logic         OUT_VALID;
  logic         STEP_ERR;

  always #5 CLK = ~CLK;

  gray2bin_seq #(.W(W)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .GRAY     (GRAY),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .BIN      (BIN),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .STEP_ERR (STEP_ERR)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: last accepted word and whether one exists since reset.
  logic [W-1:0] m_prev = '0;
  bit           m_prev_vld = 1'b0;

  // Observations captured by send_word.
  logic [W-1:0] trace [1:W+1];
  int           lat;
  logic [W-1:0] cap_bin;
  logic         cap_err;
  bit           hold_ok;
  bit           rdy_seen;
  logic         post_rdy;

  // Binary is the XOR of all right shifts of the Gray word.
  function automatic logic [W-1:0] ref_bin(input logic [W-1:0] g);
    logic [W-1:0] b = '0;
    for (int k = 0; k < W; k++) b = b ^ (g >> k);
    return b;
  endfunction

  task automatic model_accept(input logic [W-1:0] g, output logic [W-1:0] e_bin, output logic e_err);
    e_bin = ref_bin(g);
    e_err = m_prev_vld ? ($countones(g ^ m_prev) != 1) : 1'b0;
    m_prev = g;
    m_prev_vld = 1'b1;
  endtask

  task automatic reset_dut();
    RST_N = 1'b0;
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    m_prev_vld = 1'b0;
  endtask

  // Edge 1 is the accept edge; trace[n] is BIN sampled just after edge n.
  task automatic send_word(input logic [W-1:0] g, input int hold, input bit pulse);
    int n;
    int waitc;
    waitc = 0;
    while (IN_READY !== 1'b1 && waitc < 20) begin
      @(posedge CLK); #1;
      waitc++;
    end
    GRAY = g;
    IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    GRAY = W'($urandom);
    n = 1;
    trace[1] = BIN;
    while (OUT_VALID !== 1'b1 && n < 3 * W) begin
      @(posedge CLK); #1;
      n++;
      if (n <= W + 1) trace[n] = BIN;
    end
    lat = (OUT_VALID === 1'b1) ? n : -1;
    cap_bin = BIN;
    cap_err = STEP_ERR;
    hold_ok = 1'b1;
    rdy_seen = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (pulse) begin
        IN_VALID = 1'($urandom_range(0, 1));
        GRAY = W'($urandom);
      end
      @(posedge CLK); #1;
      if (BIN !== cap_bin || STEP_ERR !== cap_err || OUT_VALID !== 1'b1) hold_ok = 1'b0;
      if (IN_READY !== 1'b0) rdy_seen = 1'b1;
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    post_rdy = IN_READY;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    IN_VALID = 1'b1;
    OUT_READY = 1'b1;
    GRAY = 4'b1010;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", IN_READY); end
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", OUT_VALID); end
    checks++; if (BIN !== '0) begin errors++; $display("FAIL reset_bin got %b want 0000", BIN); end
    checks++; if (STEP_ERR !== 1'b0) begin errors++; $display("FAIL reset_step_err got %b want 0", STEP_ERR); end
    RST_N = 1'b1;
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
    m_prev_vld = 1'b0;
  endtask

  task automatic test_first_word();
    logic [W-1:0] eb, mask, ones;
    logic ee;
    ones = '1;
    model_accept(4'b0110, eb, ee);
    send_word(4'b0110, 0, 1'b0);
    checks++; if (lat != W + 1) begin errors++; $display("FAIL first_latency got %0d want %0d", lat, W + 1); end
    checks++; if (cap_bin !== eb) begin errors++; $display("FAIL first_bin got %b want %b", cap_bin, eb); end
    checks++; if (cap_err !== ee) begin errors++; $display("FAIL first_step_err got %b want %b", cap_err, ee); end
    for (int n = 1; n <= W + 1; n++) begin
      mask = ones << (W - (n - 1));
      checks++;
      if (trace[n] !== (eb & mask)) begin
        errors++; $display("FAIL first_partial edge=%0d got %b want %b", n, trace[n], eb & mask);
      end
    end
    checks++; if (post_rdy !== 1'b1) begin errors++; $display("FAIL first_idle_after got %b want 1", post_rdy); end
  endtask

  task automatic test_sweep();
    logic [W-1:0] eb, cnt, g;
    logic ee;
    reset_dut();
    for (int i = 0; i <= 16; i++) begin
      cnt = W'(i % 16);
      g = cnt ^ (cnt >> 1);
      model_accept(g, eb, ee);
      send_word(g, $urandom_range(0, 2), 1'b0);
      checks++; if (cap_bin !== cnt) begin errors++; $display("FAIL sweep_bin i=%0d got %b want %b", i, cap_bin, cnt); end
      checks++; if (cap_err !== ee) begin errors++; $display("FAIL sweep_step_err i=%0d got %b want %b", i, cap_err, ee); end
      checks++; if (lat != W + 1) begin errors++; $display("FAIL sweep_latency i=%0d got %0d want %0d", i, lat, W + 1); end
    end
  endtask

  task automatic test_step_err();
    logic [W-1:0] words [3];
    logic [W-1:0] eb;
    logic ee;
    words[0] = 4'b0000;
    words[1] = 4'b0011;
    words[2] = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      model_accept(words[i], eb, ee);
      send_word(words[i], 1, 1'b0);
      checks++; if (cap_bin !== eb) begin errors++; $display("FAIL step_bin i=%0d got %b want %b", i, cap_bin, eb); end
      checks++; if (cap_err !== ee) begin errors++; $display("FAIL step_err i=%0d got %b want %b", i, cap_err, ee); end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] g, eb;
    logic ee;
    g = m_prev ^ (W'(1) << $urandom_range(0, W - 1));
    model_accept(g, eb, ee);
    send_word(g, 10, 1'b1);
    checks++; if (hold_ok !== 1'b1) begin errors++; $display("FAIL stall_stable got %b want 1", hold_ok); end
    checks++; if (rdy_seen !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b want 0", rdy_seen); end
    checks++; if (cap_bin !== eb) begin errors++; $display("FAIL stall_bin got %b want %b", cap_bin, eb); end
    // Pulses during the stall must not have replaced the reference word.
    g = m_prev ^ (W'(1) << $urandom_range(0, W - 1));
    model_accept(g, eb, ee);
    send_word(g, 0, 1'b0);
    checks++; if (cap_err !== ee) begin errors++; $display("FAIL stall_next_err got %b want %b", cap_err, ee); end
    checks++; if (cap_bin !== eb) begin errors++; $display("FAIL stall_next_bin got %b want %b", cap_bin, eb); end
  endtask

  task automatic test_reset_midconv();
    logic [W-1:0] eb;
    logic ee;
    bit saw_vld;
    int waitc;
    waitc = 0;
    while (IN_READY !== 1'b1 && waitc < 20) begin @(posedge CLK); #1; waitc++; end
    model_accept(4'b1111, eb, ee);
    GRAY = 4'b1111;
    IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    @(posedge CLK); #1;
    checks++; if (BIN !== 4'b1000) begin errors++; $display("FAIL midconv_partial got %b want 1000", BIN); end
    RST_N = 1'b0;
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    OUT_READY = 1'b0;
    m_prev_vld = 1'b0;
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL midconv_out_valid got %b want 0", OUT_VALID); end
    checks++; if (BIN !== '0) begin errors++; $display("FAIL midconv_bin got %b want 0000", BIN); end
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL midconv_in_ready got %b want 1", IN_READY); end
    saw_vld = 1'b0;
    repeat (W + 2) begin
      @(posedge CLK); #1;
      if (OUT_VALID !== 1'b0) saw_vld = 1'b1;
    end
    checks++; if (saw_vld !== 1'b0) begin errors++; $display("FAIL midconv_no_output got %b want 0", saw_vld); end
    model_accept(4'b0001, eb, ee);
    send_word(4'b0001, 0, 1'b0);
    checks++; if (cap_err !== ee) begin errors++; $display("FAIL midconv_next_err got %b want %b", cap_err, ee); end
    checks++; if (cap_bin !== eb) begin errors++; $display("FAIL midconv_next_bin got %b want %b", cap_bin, eb); end
  endtask

  task automatic test_random();
    logic [W-1:0] g, eb;
    logic ee;
    int mode;
    for (int i = 0; i < 24; i++) begin
      mode = $urandom_range(0, 3);
      if (mode == 0)      g = W'($urandom);
      else if (mode == 1) g = m_prev;
      else                g = m_prev ^ (W'(1) << $urandom_range(0, W - 1));
      model_accept(g, eb, ee);
      send_word(g, $urandom_range(0, 3), 1'b1);
      checks++; if (cap_bin !== eb) begin errors++; $display("FAIL rand_bin i=%0d gray=%b got %b want %b", i, g, cap_bin, eb); end
      checks++; if (cap_err !== ee) begin errors++; $display("FAIL rand_err i=%0d gray=%b got %b want %b", i, g, cap_err, ee); end
      checks++; if (lat != W + 1) begin errors++; $display("FAIL rand_latency i=%0d got %0d want %0d", i, lat, W + 1); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_bin_q [$];
    logic         exp_err_q [$];
    logic [W-1:0] g, eb;
    logic ee;
    int sent, got, last, cyc;
    sent = 0; got = 0; last = -1; cyc = 0;
    OUT_READY = 1'b1;
    while (got < 8 && cyc < 200) begin
      if (IN_READY === 1'b1 && sent < 8) begin
        g = m_prev ^ (W'(1) << $urandom_range(0, W - 1));
        GRAY = g;
        IN_VALID = 1'b1;
        model_accept(g, eb, ee);
        exp_bin_q.push_back(eb);
        exp_err_q.push_back(ee);
        sent++;
      end else if (IN_READY === 1'b1) begin
        IN_VALID = 1'b0;
      end
      @(posedge CLK); #1;
      cyc++;
      if (OUT_VALID === 1'b1 && exp_bin_q.size() > 0) begin
        eb = exp_bin_q.pop_front();
        ee = exp_err_q.pop_front();
        checks++; if (BIN !== eb) begin errors++; $display("FAIL b2b_bin n=%0d got %b want %b", got, BIN, eb); end
        checks++; if (STEP_ERR !== ee) begin errors++; $display("FAIL b2b_err n=%0d got %b want %b", got, STEP_ERR, ee); end
        if (last >= 0) begin
          checks++; if (cyc - last != W + 2) begin errors++; $display("FAIL b2b_spacing n=%0d got %0d want %0d", got, cyc - last, W + 2); end
        end
        last = cyc;
        got++;
      end
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
    checks++; if (got != 8) begin errors++; $display("FAIL b2b_count got %0d want 8", got); end
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_sweep();
    test_step_err();
    test_stall();
    test_reset_midconv();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
